// File: rtl/eth_decap.sv
`default_nettype none
// ============================================================================
// eth_decap : validate/strip 48B Eth+IPv4+UDP+TCAP header, TLP beats -> FIFO
// Optional: ETH_DECAP_IPCHECK_EN (IPv4 header checksum check)  | Rev 1.0
// ============================================================================
module eth_decap #(
  parameter logic [47:0] ETH_DST   = 48'h90_E2_BA_5D_8D_C9,
  parameter logic [31:0] IP_DADDR  = {8'd192, 8'd168, 8'd11, 8'd3},
  parameter logic [15:0] UDP_DPORT = 16'h3776,
  parameter logic [1:0]  TCAP_VER  = 2'b01
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        wr_en,
  output logic [73:0] din,
  input  logic        full,
  output logic [39:0] tcap_ts,
  output logic [31:0] frame_ok_cnt,
  output logic [31:0] frame_drop_cnt
);

  typedef enum logic [1:0] {
    RX_HDR  = 2'd0,
    RX_DATA = 2'd1,
    RX_DROP = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  beat_cnt;
  logic        match;
  logic        beat_ok;
  logic        beat_good;
  logic        ck_ok;
  logic        hs;
  logic [7:0]  b [0:7];
  logic [47:0] dst_mac;

  for (genvar i = 0; i < 8; i++) begin : g_bytes
    assign b[i] = s_axis_tdata[8*i +: 8];
  end

  assign dst_mac = {b[0], b[1], b[2], b[3], b[4], b[5]};

  // Field checks owned by the header beat currently on the bus
  always_comb begin
    beat_ok = 1'b1;
    case (beat_cnt)
      3'd0: beat_ok = (dst_mac == ETH_DST) || (dst_mac == {48{1'b1}});
      3'd1: beat_ok = ({b[4], b[5]} == 16'h0800) && (b[6] == 8'h45);
      3'd2: beat_ok = (b[7] == 8'h11);
      3'd3: beat_ok = ({b[6], b[7]} == IP_DADDR[31:16]);
      3'd4: beat_ok = ({b[0], b[1]} == IP_DADDR[15:0]) && ({b[4], b[5]} == UDP_DPORT);
      3'd5: beat_ok = (b[2][7:6] == TCAP_VER);
      default: beat_ok = 1'b1;
    endcase
  end

  assign beat_good = beat_ok && !s_axis_tuser && (s_axis_tkeep == 8'hFF);

  assign s_axis_tready = sys_rst_n && !((state == RX_DATA) && full);
  assign wr_en         = sys_rst_n && (state == RX_DATA) && s_axis_tvalid && !full;
  assign din           = {s_axis_tkeep, s_axis_tdata, s_axis_tlast, s_axis_tuser};
  assign hs            = s_axis_tvalid && s_axis_tready;

`ifdef ETH_DECAP_IPCHECK_EN
  logic [19:0] ck_acc;
  logic [19:0] ck_beat;
  logic [16:0] ck_f1;
  logic [15:0] ck_fold;

  // Bytes 14..33 as big-endian 16-bit words, spread over header beats 1..4
  always_comb begin
    ck_beat = '0;
    case (beat_cnt)
      3'd1: ck_beat = {4'd0, b[6], b[7]};
      3'd2, 3'd3: ck_beat = {4'd0, b[0], b[1]} + {4'd0, b[2], b[3]}
                          + {4'd0, b[4], b[5]} + {4'd0, b[6], b[7]};
      3'd4: ck_beat = {4'd0, b[0], b[1]};
      default: ck_beat = '0;
    endcase
    ck_f1   = {1'b0, ck_acc[15:0]} + {13'd0, ck_acc[19:16]};
    ck_fold = ck_f1[15:0] + {15'd0, ck_f1[16]};
  end

  assign ck_ok = (ck_fold == 16'hFFFF);

  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      ck_acc <= '0;
    end else if (hs && (state == RX_HDR)) begin
      ck_acc <= (beat_cnt == 3'd0) ? 20'd0 : ck_acc + ck_beat;
    end
  end
`else
  assign ck_ok = 1'b1;
`endif

  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      state          <= RX_HDR;
      beat_cnt       <= 3'd0;
      match          <= 1'b1;
      tcap_ts        <= '0;
      frame_ok_cnt   <= '0;
      frame_drop_cnt <= '0;
    end else if (hs) begin
      case (state)
        RX_HDR: begin
          if (s_axis_tlast) begin
            beat_cnt       <= 3'd0;
            match          <= 1'b1;
            frame_drop_cnt <= (frame_drop_cnt == '1) ? frame_drop_cnt : frame_drop_cnt + 32'd1;
          end else if (beat_cnt == 3'd5) begin
            beat_cnt <= 3'd0;
            match    <= 1'b1;
            if (match && beat_good && ck_ok) begin
              state        <= RX_DATA;
              tcap_ts      <= {b[3], b[4], b[5], b[6], b[7]};
              frame_ok_cnt <= (frame_ok_cnt == '1) ? frame_ok_cnt : frame_ok_cnt + 32'd1;
            end else begin
              state <= RX_DROP;
            end
          end else begin
            beat_cnt <= beat_cnt + 3'd1;
            match    <= match && beat_good;
          end
        end
        RX_DATA: begin
          if (s_axis_tlast) begin
            state    <= RX_HDR;
            beat_cnt <= 3'd0;
            match    <= 1'b1;
          end
        end
        RX_DROP: begin
          if (s_axis_tlast) begin
            state          <= RX_HDR;
            beat_cnt       <= 3'd0;
            match          <= 1'b1;
            frame_drop_cnt <= (frame_drop_cnt == '1) ? frame_drop_cnt : frame_drop_cnt + 32'd1;
          end
        end
        default: begin
          state    <= RX_HDR;
          beat_cnt <= 3'd0;
          match    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_decap.sv
`default_nettype none
// ============================================================================
// tb_eth_decap : directed vector table + randomized frames vs byte-level model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_eth_decap;

  localparam logic [47:0] DST = 48'h90E2BA5D8DC9;

  logic        clk156 = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        wr_en;
  logic [73:0] din;
  logic        full = 1'b0;
  logic [39:0] tcap_ts;
  logic [31:0] frame_ok_cnt;
  logic [31:0] frame_drop_cnt;

  always #3 clk156 = ~clk156;

  eth_decap dut (
    .clk156(clk156), .sys_rst_n(sys_rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .wr_en(wr_en), .din(din), .full(full), .tcap_ts(tcap_ts),
    .frame_ok_cnt(frame_ok_cnt), .frame_drop_cnt(frame_drop_cnt)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Every write the DUT will commit at the next rising edge
  logic [73:0] wq[$];
  always @(negedge clk156) if (wr_en) wq.push_back(din);

  logic [7:0]  hdr [48];
  logic [63:0] fd[$];
  logic [7:0]  fk[$];
  logic        fl[$];
  logic        fu[$];
  logic [73:0] exp_q[$];
  logic [31:0] e_ok = 0, e_drop = 0;
  logic [39:0] e_ts = 0;
  int notready, fullcyc, viol;

  task automatic fix_cksum();
    logic [31:0] s;
    hdr[24] = 8'h00; hdr[25] = 8'h00;
    s = 0;
    for (int j = 14; j < 34; j += 2) s += {16'h0, hdr[j], hdr[j+1]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    {hdr[24], hdr[25]} = ~s[15:0];
  endtask

  task automatic build_hdr(input logic [47:0] dst, input logic [39:0] ts);
    for (int j = 0; j < 48; j++) hdr[j] = 8'($urandom);
    for (int i = 0; i < 6; i++) hdr[i] = dst[8*(5-i) +: 8];
    hdr[12] = 8'h08; hdr[13] = 8'h00; hdr[14] = 8'h45; hdr[23] = 8'h11;
    hdr[30] = 8'd192; hdr[31] = 8'd168; hdr[32] = 8'd11; hdr[33] = 8'd3;
    hdr[36] = 8'h37; hdr[37] = 8'h76;
    hdr[42] = {2'b01, hdr[42][5:0]};
    for (int i = 0; i < 5; i++) hdr[43+i] = ts[8*(4-i) +: 8];
    fix_cksum();
  endtask

  task automatic make_frame(input int npay, input logic [7:0] lkeep, input int huser,
                            input int puser, input int runt, input int hkb);
    int nb;
    logic [63:0] w;
    fd.delete(); fk.delete(); fl.delete(); fu.delete();
    nb = (runt >= 0) ? runt + 1 : 6 + npay;
    for (int bt = 0; bt < nb; bt++) begin
      if (bt < 6) for (int k = 0; k < 8; k++) w[8*k +: 8] = hdr[8*bt + k];
      else w = {$urandom, $urandom};
      fd.push_back(w);
      fk.push_back((bt >= 6 && bt == nb - 1) ? lkeep : ((bt == hkb) ? 8'hF7 : 8'hFF));
      fl.push_back(bt == nb - 1);
      fu.push_back((bt == huser) || (puser >= 0 && bt == 6 + puser));
    end
  endtask

  // Frame-level reference: decide acceptance from the header bytes, emit payload words
  task automatic model(output bit acc, output logic [39:0] ts);
    logic [7:0]  by [48];
    logic [63:0] w;
    logic [47:0] d;
    logic [31:0] s;
    for (int j = 0; j < 48; j++) begin
      if (j / 8 < fd.size()) begin w = fd[j/8]; by[j] = w[8*(j%8) +: 8]; end
      else by[j] = 8'h00;
    end
    acc = (fd.size() > 6);
    for (int bt = 0; bt < 6 && bt < fd.size(); bt++) if (fu[bt] || fk[bt] != 8'hFF) acc = 0;
    d = {by[0], by[1], by[2], by[3], by[4], by[5]};
    if (d != DST && d != {48{1'b1}}) acc = 0;
    if ({by[12], by[13]} != 16'h0800 || by[14] != 8'h45 || by[23] != 8'h11) acc = 0;
    if ({by[30], by[31], by[32], by[33]} != {8'd192, 8'd168, 8'd11, 8'd3}) acc = 0;
    if ({by[36], by[37]} != 16'h3776 || by[42][7:6] != 2'b01) acc = 0;
`ifdef ETH_DECAP_IPCHECK_EN
    s = 0;
    for (int j = 14; j < 34; j += 2) s += {16'h0, by[j], by[j+1]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    if (s[15:0] != 16'hFFFF) acc = 0;
`endif
    ts = {by[43], by[44], by[45], by[46], by[47]};
    if (acc) for (int bt = 6; bt < fd.size(); bt++) exp_q.push_back({fk[bt], fd[bt], fl[bt], fu[bt]});
  endtask

  task automatic send_frame(input int nsend, input int stall_at, input int stall_len, input bit rnd);
    int cyc;
    bit done, in_stall;
    cyc = 0; notready = 0; fullcyc = 0; viol = 0;
    for (int i = 0; i < nsend; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0; full = 1'($urandom_range(0, 1));
        @(posedge clk156); #1; cyc++;
      end
      s_axis_tvalid = 1'b1; s_axis_tdata = fd[i]; s_axis_tkeep = fk[i];
      s_axis_tlast = fl[i]; s_axis_tuser = fu[i];
      done = 0;
      for (int t = 0; t < 200 && !done; t++) begin
        in_stall = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
        full = in_stall || (rnd && $urandom_range(0, 3) == 0);
        @(negedge clk156);
        if (in_stall) begin fullcyc++; if (s_axis_tready || wr_en) viol++; end
        if (!full && !s_axis_tready) notready++;
        done = s_axis_tready;
        @(posedge clk156); #1; cyc++;
      end
      if (!done) begin
        checks++;
        $display("FAIL handshake_timeout: beat %0d never accepted", i);
        break;
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; full = 1'b0;
    repeat (2) @(posedge clk156);
    #1;
  endtask

  task automatic compare_frame(input string tag);
    check({tag, " nwr"}, 80'(wq.size()), 80'(exp_q.size()));
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      check($sformatf("%s wr%0d", tag, i), 80'(wq[i]), 80'(exp_q[i]));
    check({tag, " ok_cnt"}, 80'(frame_ok_cnt), 80'(e_ok));
    check({tag, " drop_cnt"}, 80'(frame_drop_cnt), 80'(e_drop));
    check({tag, " tcap_ts"}, 80'(tcap_ts), 80'(e_ts));
    wq.delete(); exp_q.delete();
  endtask

  typedef struct {
    logic [47:0] dst;
    logic [39:0] ts;
    int          npay;
    logic [7:0]  lkeep;
    int          huser;
    int          puser;
    int          runt;
    bit          bad_ck;
    int          eok;
    int          edrop;
    int          ewr;
  } vec_t;

  vec_t        vt [8];
  bit          acc;
  logic [39:0] mts;
  int          kind, npay, huser, puser, runt, hkb;
  logic [47:0] d;

  initial begin
    vt[0] = '{DST,            40'hAAAAAAAAAA, 3, 8'h0F, -1, -1, -1, 1'b0, 1, 0, 3};
    vt[1] = '{48'h000000000001, 40'h1111111111, 2, 8'hFF, -1, -1, -1, 1'b0, 0, 1, 0};
    vt[2] = '{DST,            40'h2222222222, 3, 8'hFF, -1, -1,  3, 1'b0, 0, 1, 0};
    vt[3] = '{DST,            40'h3333333333, 2, 8'hFF, -1, -1, -1, 1'b0, 1, 0, 2};
    vt[4] = '{DST,            40'h4444444444, 3, 8'hFF, -1,  2, -1, 1'b0, 1, 0, 3};
    vt[5] = '{DST,            40'h5555555555, 2, 8'hFF,  2, -1, -1, 1'b0, 0, 1, 0};
`ifdef ETH_DECAP_IPCHECK_EN
    vt[6] = '{DST,            40'h6666666666, 2, 8'h03, -1, -1, -1, 1'b1, 0, 1, 0};
`else
    vt[6] = '{DST,            40'h6666666666, 2, 8'h03, -1, -1, -1, 1'b1, 1, 0, 2};
`endif
    vt[7] = '{48'hFFFFFFFFFFFF, 40'h7777777777, 1, 8'h01, -1, -1, -1, 1'b0, 1, 0, 1};

    // Reset: ready and write strobe held low even with data offered
    sys_rst_n = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 64'hDEADBEEF_01234567;
    s_axis_tkeep = 8'hFF;
    repeat (3) @(posedge clk156);
    @(negedge clk156);
    check("rst tready", 80'(s_axis_tready), 80'(0));
    check("rst wr_en", 80'(wr_en), 80'(0));
    @(posedge clk156); #1;
    s_axis_tvalid = 1'b0; sys_rst_n = 1'b1;
    @(posedge clk156); #1;
    check("rst ok_cnt", 80'(frame_ok_cnt), 80'(0));
    check("rst drop_cnt", 80'(frame_drop_cnt), 80'(0));
    check("rst tcap_ts", 80'(tcap_ts), 80'(0));
    check("idle tready", 80'(s_axis_tready), 80'(1));
    wq.delete();

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      build_hdr(vt[v].dst, vt[v].ts);
      if (vt[v].bad_ck) hdr[24] = hdr[24] ^ 8'h01;
      make_frame(vt[v].npay, vt[v].lkeep, vt[v].huser, vt[v].puser, vt[v].runt, -1);
      model(acc, mts);
      send_frame(fd.size(), 0, 0, 1'b0);
      e_ok   += 32'(vt[v].eok);
      e_drop += 32'(vt[v].edrop);
      if (vt[v].eok != 0) e_ts = vt[v].ts;
      check($sformatf("vec%0d writes", v), 80'(wq.size()), 80'(vt[v].ewr));
      check($sformatf("vec%0d tready_low", v), 80'(notready), 80'(0));
      if (vt[v].ewr > 0 && wq.size() == vt[v].ewr) begin
        check($sformatf("vec%0d last_keep", v), 80'(wq[vt[v].ewr-1][73:66]), 80'(vt[v].lkeep));
        check($sformatf("vec%0d last_flag", v), 80'(wq[vt[v].ewr-1][1]), 80'(1));
        if (vt[v].puser >= 0)
          check($sformatf("vec%0d pay_tuser", v), 80'(wq[vt[v].puser][0]), 80'(1));
      end
      compare_frame($sformatf("vec%0d", v));
    end

    // FIFO full for 4 cycles on payload beat 2
    build_hdr(DST, 40'h0123456789);
    make_frame(5, 8'h3F, -1, -1, -1, -1);
    model(acc, mts);
    e_ok += 1; e_ts = 40'h0123456789;
    send_frame(fd.size(), 8, 4, 1'b0);
    check("stall cycles", 80'(fullcyc), 80'(4));
    check("stall tready/wr_en", 80'(viol), 80'(0));
    check("stall writes", 80'(wq.size()), 80'(5));
    compare_frame("stall");

    // Randomized frames, random gaps and backpressure
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 14);
      npay = $urandom_range(1, 5);
      huser = -1; hkb = -1; runt = -1;
      puser = $urandom_range(0, 1) ? $urandom_range(0, npay - 1) : -1;
      d = (kind == 3) ? {48{1'b1}} : DST;
      build_hdr(d, {$urandom, 8'($urandom)});
      case (kind)
        4:  hdr[5]  = hdr[5] ^ 8'h01;
        5:  hdr[13] = 8'h06;
        6:  begin hdr[14] = 8'h46; fix_cksum(); end
        7:  begin hdr[23] = 8'h06; fix_cksum(); end
        8:  begin hdr[33] = hdr[33] ^ 8'h10; fix_cksum(); end
        9:  hdr[37] = hdr[37] ^ 8'h01;
        10: hdr[42] = {2'b10, hdr[42][5:0]};
        11: hdr[25] = hdr[25] ^ 8'h80;
        12: huser = $urandom_range(0, 5);
        13: hkb   = $urandom_range(0, 5);
        14: runt  = $urandom_range(0, 5);
        default: ;
      endcase
      make_frame(npay, 8'($urandom_range(1, 255)), huser, puser, runt, hkb);
      model(acc, mts);
      if (acc) begin e_ok += 1; e_ts = mts; end
      else e_drop += 1;
      send_frame(fd.size(), 0, 0, 1'b1);
      compare_frame($sformatf("rnd%0d k%0d", f, kind));
    end

    // Reset in the middle of a payload, then a clean frame
    build_hdr(DST, 40'h5A5A5A5A5A);
    make_frame(3, 8'hFF, -1, -1, -1, -1);
    send_frame(7, 0, 0, 1'b0);
    s_axis_tvalid = 1'b1; s_axis_tdata = fd[7]; s_axis_tkeep = fk[7];
    s_axis_tlast = fl[7];
    sys_rst_n = 1'b0;
    @(negedge clk156);
    check("midrst tready", 80'(s_axis_tready), 80'(0));
    check("midrst wr_en", 80'(wr_en), 80'(0));
    @(posedge clk156); #1;
    @(posedge clk156); #1;
    sys_rst_n = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    @(posedge clk156); #1;
    e_ok = 0; e_drop = 0; e_ts = 0;
    wq.delete(); exp_q.delete();
    check("midrst ok_cnt", 80'(frame_ok_cnt), 80'(0));
    check("midrst drop_cnt", 80'(frame_drop_cnt), 80'(0));
    build_hdr(DST, 40'hC3C3C3C3C3);
    make_frame(2, 8'h0F, -1, -1, -1, -1);
    model(acc, mts);
    e_ok += 1; e_ts = 40'hC3C3C3C3C3;
    send_frame(fd.size(), 0, 0, 1'b0);
    compare_frame("post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
